tank_engine: RTL and testbench

Parametrised N-player motion engine for the tank game: replaces the per-player `tank` instances, which all shared a single keycode and moved in lockstep. Once per video frame it reads up to `NUM_KEYS` simultaneous USB keycodes from the SoC and applies each tank's own key bindings. It then moves each tank in sequence, clamping to the screen and blocking moves that would overlap another tank. It sits between the SoC keycode export and `color_mapper`, clocked from `MAX10_CLK1_50`.

---
 rtl/tank_pkg.sv | 38 +++
 rtl/tank_move_calc.sv | 57 +++++
 rtl/tank_engine.sv | 209 ++++++++++++++++++++
 tb/tb_tank_engine.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types, binding-slot indices and spawn helpers for the multi-tank
// motion engine.
package tank_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        UPDATE = 2'b01,
        DONE   = 2'b10
    } eng_state_t;

    // Byte positions of each binding inside a tank's 32-bit keymap word.
    localparam int KEY_UP    = 3;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 0;

    typedef struct packed {
        logic move;
        dir_t dir;
    } intent_t;

    function automatic int spawn_x(input int idx, input int num_tanks,
                                   input int screen_w, input int tank_size);
        return (idx + 1) * screen_w / (num_tanks + 1) - tank_size / 2;
    endfunction

    function automatic int spawn_y(input int screen_h, input int tank_size);
        return screen_h / 2 - tank_size / 2;
    endfunction

endpackage

// File: rtl/tank_move_calc.sv
// Combinational one-step move: applies the intent to a position and clamps
// the result to the playfield.
module tank_move_calc
    import tank_pkg::*;
#(
    parameter int COORD_W = 10,
    parameter int STEP    = 1,
    parameter int X_MAX   = 624,
    parameter int Y_MAX   = 464
) (
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  intent_t            intent,
    output logic [COORD_W-1:0] cand_x,
    output logic [COORD_W-1:0] cand_y
);

    typedef logic signed [COORD_W:0] scoord_t;

    localparam scoord_t STEP_S  = scoord_t'(STEP);
    localparam scoord_t X_MAX_S = scoord_t'(X_MAX);
    localparam scoord_t Y_MAX_S = scoord_t'(Y_MAX);

    // One spare bit lets a step past the left/top edge go negative instead of wrapping.
    function automatic logic [COORD_W-1:0] clamp(input scoord_t v, input scoord_t hi);
        if (v[COORD_W]) begin
            return '0;
        end
        if (v > hi) begin
            return hi[COORD_W-1:0];
        end
        return v[COORD_W-1:0];
    endfunction

    scoord_t sx;
    scoord_t sy;
    scoord_t nx;
    scoord_t ny;

    always_comb begin
        sx = scoord_t'({1'b0, cur_x});
        sy = scoord_t'({1'b0, cur_y});
        nx = sx;
        ny = sy;
        if (intent.move) begin
            unique case (intent.dir)
                UP:    ny = sy - STEP_S;
                DOWN:  ny = sy + STEP_S;
                LEFT:  nx = sx - STEP_S;
                RIGHT: nx = sx + STEP_S;
            endcase
        end
        cand_x = clamp(nx, X_MAX_S);
        cand_y = clamp(ny, Y_MAX_S);
    end

endmodule

// File: rtl/tank_engine.sv
// Per-frame N-tank motion engine: on each vsync fall, walks the tanks in index
// order, applying each tank's own key bindings with clamping and collision blocking.
module tank_engine
    import tank_pkg::*;
#(
    parameter int NUM_TANKS = 2,
    parameter int NUM_KEYS  = 4,
    parameter int COORD_W   = 10,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int TANK_SIZE = 16,
    parameter int STEP      = 1
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         frame_vs,
    input  logic [NUM_KEYS*8-1:0]        keycodes,
    input  logic [NUM_TANKS*32-1:0]      keymap,
    output logic [NUM_TANKS*COORD_W-1:0] TankX,
    output logic [NUM_TANKS*COORD_W-1:0] TankY,
    output logic [NUM_TANKS*2-1:0]       TankDir,
    output logic                         frame_done
);

    localparam int IDX_W = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_TANKS - 1);
    localparam logic [COORD_W-1:0] SPAWN_Y  = COORD_W'(spawn_y(SCREEN_H, TANK_SIZE));

    typedef logic signed [COORD_W:0] scoord_t;
    localparam scoord_t SIZE_S = scoord_t'(TANK_SIZE);

    eng_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vs_q, vs_d;
    logic               frame_done_q, frame_done_d;
    logic [COORD_W-1:0] x_q [NUM_TANKS];
    logic [COORD_W-1:0] x_d [NUM_TANKS];
    logic [COORD_W-1:0] y_q [NUM_TANKS];
    logic [COORD_W-1:0] y_d [NUM_TANKS];
    dir_t               dir_q [NUM_TANKS];
    dir_t               dir_d [NUM_TANKS];

    logic               tick;
    logic [31:0]        bind_cur;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic [COORD_W-1:0] cand_x;
    logic [COORD_W-1:0] cand_y;
    logic [3:0]         hit;
    intent_t            intent;
    logic               blocked;

    function automatic logic overlaps(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                      input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
        scoord_t dx;
        scoord_t dy;
        dx = scoord_t'({1'b0, ax}) - scoord_t'({1'b0, bx});
        dy = scoord_t'({1'b0, ay}) - scoord_t'({1'b0, by});
        if (dx[COORD_W]) begin
            dx = -dx;
        end
        if (dy[COORD_W]) begin
            dy = -dy;
        end
        return (dx < SIZE_S) && (dy < SIZE_S);
    endfunction

    assign vs_d = frame_vs;
    assign tick = vs_q & ~frame_vs;

    // Select the tank being updated this cycle.
    always_comb begin
        cur_x    = x_q[0];
        cur_y    = y_q[0];
        bind_cur = keymap[31:0];
        for (int i = 1; i < NUM_TANKS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_x    = x_q[i];
                cur_y    = y_q[i];
                bind_cur = keymap[i*32 +: 32];
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < NUM_KEYS; s++) begin
                if (bind_cur[b*8 +: 8] != 8'h00 && keycodes[s*8 +: 8] == bind_cur[b*8 +: 8]) begin
                    hit[b] = 1'b1;
                end
            end
        end

        intent.move = 1'b1;
        intent.dir  = UP;
        if (hit[KEY_UP]) begin
            intent.dir = UP;
        end else if (hit[KEY_DOWN]) begin
            intent.dir = DOWN;
        end else if (hit[KEY_LEFT]) begin
            intent.dir = LEFT;
        end else if (hit[KEY_RIGHT]) begin
            intent.dir = RIGHT;
        end else begin
            intent.move = 1'b0;
        end
    end

    tank_move_calc #(
        .COORD_W (COORD_W),
        .STEP    (STEP),
        .X_MAX   (SCREEN_W - TANK_SIZE),
        .Y_MAX   (SCREEN_H - TANK_SIZE)
    ) u_move_calc (
        .cur_x  (cur_x),
        .cur_y  (cur_y),
        .intent (intent),
        .cand_x (cand_x),
        .cand_y (cand_y)
    );

    // Registers are read directly, so lower-index tanks already show this frame's move.
    always_comb begin
        blocked = 1'b0;
        for (int j = 0; j < NUM_TANKS; j++) begin
            if (idx_q != IDX_W'(j) && overlaps(cand_x, cand_y, x_q[j], y_q[j])) begin
                blocked = 1'b1;
            end
        end
    end

    // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        dir_d        = dir_q;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                for (int i = 0; i < NUM_TANKS; i++) begin
                    if (idx_q == IDX_W'(i) && intent.move) begin
                        dir_d[i] = intent.dir;
                        if (!blocked) begin
                            x_d[i] = cand_x;
                            y_d[i] = cand_y;
                        end
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d      = DONE;
                    idx_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the per-tank arrays are a handful of flops, not RAM, so they reset to spawn.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            vs_q         <= 1'b1;
            frame_done_q <= 1'b0;
            for (int i = 0; i < NUM_TANKS; i++) begin
                x_q[i]   <= COORD_W'(spawn_x(i, NUM_TANKS, SCREEN_W, TANK_SIZE));
                y_q[i]   <= SPAWN_Y;
                dir_q[i] <= UP;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            vs_q         <= vs_d;
            frame_done_q <= frame_done_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dir_q        <= dir_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_TANKS; i++) begin
            TankX[i*COORD_W +: COORD_W] = x_q[i];
            TankY[i*COORD_W +: COORD_W] = y_q[i];
            TankDir[i*2 +: 2]           = dir_q[i];
        end
    end

    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tank_engine.sv
// Self-checking bench for tank_engine: directed scenarios plus randomized frames
// compared against a plain-arithmetic model of the movement rules.
module tb_tank_engine;

    localparam int N    = 2;
    localparam int K    = 4;
    localparam int CW   = 10;
    localparam int SW   = 640;
    localparam int SH   = 480;
    localparam int TS   = 16;
    localparam int STEP = 1;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic            frame_vs;
    logic [K*8-1:0]  keycodes;
    logic [N*32-1:0] keymap;
    logic [N*CW-1:0] TankX;
    logic [N*CW-1:0] TankY;
    logic [N*2-1:0]  TankDir;
    logic            frame_done;

    tank_engine #(
        .NUM_TANKS (N), .NUM_KEYS (K), .COORD_W (CW), .SCREEN_W (SW),
        .SCREEN_H (SH), .TANK_SIZE (TS), .STEP (STEP)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_vs   (frame_vs),
        .keycodes   (keycodes),
        .keymap     (keymap),
        .TankX      (TankX),
        .TankY      (TankY),
        .TankDir    (TankDir),
        .frame_done (frame_done)
    );

    always #5 Clk = ~Clk;

    int pass_cnt;
    int total_cnt;

    // Model state. Direction codes: 0 up, 1 down, 2 left, 3 right.
    int mx [N];
    int my [N];
    int mdir [N];
    // Bindings per tank in priority order: up, down, left, right.
    logic [7:0] bind_code [N][4];

    function automatic int obs_x(input int t);
        return int'(TankX[t*CW +: CW]);
    endfunction

    function automatic int obs_y(input int t);
        return int'(TankY[t*CW +: CW]);
    endfunction

    function automatic int obs_d(input int t);
        return int'(TankDir[t*2 +: 2]);
    endfunction

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic bit held(input logic [K*8-1:0] kc, input logic [7:0] code);
        if (code == 8'h00) return 1'b0;
        for (int s = 0; s < K; s++) begin
            if (kc[s*8 +: 8] == code) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i]   = (i + 1) * SW / (N + 1) - TS / 2;
            my[i]   = SH / 2 - TS / 2;
            mdir[i] = 0;
        end
    endtask

    task automatic model_frame(input logic [K*8-1:0] kc);
        int  d;
        int  nx;
        int  ny;
        bit  clash;
        for (int t = 0; t < N; t++) begin
            d = -1;
            for (int b = 0; b < 4; b++) begin
                if (d < 0 && held(kc, bind_code[t][b])) d = b;
            end
            if (d >= 0) begin
                mdir[t] = d;
                nx = mx[t];
                ny = my[t];
                case (d)
                    0: ny = ny - STEP;
                    1: ny = ny + STEP;
                    2: nx = nx - STEP;
                    default: nx = nx + STEP;
                endcase
                nx = clampi(nx, 0, SW - TS);
                ny = clampi(ny, 0, SH - TS);
                clash = 1'b0;
                for (int j = 0; j < N; j++) begin
                    if (j != t && absi(nx - mx[j]) < TS && absi(ny - my[j]) < TS) clash = 1'b1;
                end
                if (!clash) begin
                    mx[t] = nx;
                    my[t] = ny;
                end
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        model_reset();
    endtask

    // Drives one vsync fall and watches frame_done for a bounded window.
    // done_at is the cycle offset from the tick cycle, -1 if never seen.
    task automatic run_frame(input logic [K*8-1:0] kc, output int done_at, output int pulses);
        keycodes = kc;
        @(posedge Clk); #1;
        frame_vs = 1'b0;
        done_at  = -1;
        pulses   = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge Clk); #1;
            if (frame_done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = c;
            end
            frame_vs = 1'b1;
        end
        model_frame(kc);
    endtask

    task automatic test_reset();
        int ex [N];
        ex[0] = 205;
        ex[1] = 418;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        model_reset();
        for (int t = 0; t < N; t++) begin
            total_cnt++;
            if (obs_x(t) !== ex[t] || obs_y(t) !== 232 || obs_d(t) !== 0)
                $display("FAIL reset_pos t%0d: got (%0d,%0d,d%0d) want (%0d,232,d0)",
                         t, obs_x(t), obs_y(t), obs_d(t), ex[t]);
            else pass_cnt++;
        end
        total_cnt++;
        if (frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done);
        else pass_cnt++;
    endtask

    task automatic test_single_key();
        int done_at;
        int pulses;
        pulse_reset();
        for (int f = 0; f < 3; f++) begin
            run_frame(32'h0000_0007, done_at, pulses);
            total_cnt++;
            if (done_at !== N + 1 || pulses !== 1)
                $display("FAIL single_done_timing f%0d: got at %0d x%0d want at %0d x1", f, done_at, pulses, N + 1);
            else pass_cnt++;
        end
        total_cnt++;
        if (obs_x(0) !== 208 || obs_y(0) !== 232 || obs_d(0) !== 3)
            $display("FAIL single_t0: got (%0d,%0d,d%0d) want (208,232,d3)", obs_x(0), obs_y(0), obs_d(0));
        else pass_cnt++;
        total_cnt++;
        if (obs_x(1) !== 418 || obs_y(1) !== 232 || obs_d(1) !== 0)
            $display("FAIL single_t1: got (%0d,%0d,d%0d) want (418,232,d0)", obs_x(1), obs_y(1), obs_d(1));
        else pass_cnt++;
    endtask

    task automatic test_priority();
        int done_at;
        int pulses;
        pulse_reset();
        run_frame(32'h0000_1A07, done_at, pulses);
        total_cnt++;
        if (obs_x(0) !== 205 || obs_y(0) !== 231 || obs_d(0) !== 0)
            $display("FAIL priority_up: got (%0d,%0d,d%0d) want (205,231,d0)", obs_x(0), obs_y(0), obs_d(0));
        else pass_cnt++;
        run_frame(32'h0000_0000, done_at, pulses);
        total_cnt++;
        if (obs_x(0) !== 205 || obs_y(0) !== 231 || obs_d(0) !== 0 || done_at !== N + 1)
            $display("FAIL priority_empty: got (%0d,%0d,d%0d) done %0d want (205,231,d0) done %0d",
                     obs_x(0), obs_y(0), obs_d(0), done_at, N + 1);
        else pass_cnt++;
        // Down beats left and right for tank 1.
        run_frame(32'h4F50_5100, done_at, pulses);
        for (int t = 0; t < N; t++) begin
            total_cnt++;
            if (obs_x(t) !== mx[t] || obs_y(t) !== my[t] || obs_d(t) !== mdir[t])
                $display("FAIL priority_model t%0d: got (%0d,%0d,d%0d) want (%0d,%0d,d%0d)",
                         t, obs_x(t), obs_y(t), obs_d(t), mx[t], my[t], mdir[t]);
            else pass_cnt++;
        end
    endtask

    task automatic test_wall();
        int done_at;
        int pulses;
        int bad_timing;
        pulse_reset();
        bad_timing = 0;
        for (int f = 1; f <= 205; f++) begin
            run_frame(32'h0000_0004, done_at, pulses);
            if (done_at != N + 1 || pulses != 1) bad_timing++;
        end
        total_cnt++;
        if (obs_x(0) !== 0 || obs_d(0) !== 2)
            $display("FAIL wall_reach: got x %0d d%0d want x 0 d2", obs_x(0), obs_d(0));
        else pass_cnt++;
        run_frame(32'h0000_0004, done_at, pulses);
        total_cnt++;
        if (obs_x(0) !== 0 || obs_y(0) !== 232 || obs_d(0) !== 2)
            $display("FAIL wall_hold: got (%0d,%0d,d%0d) want (0,232,d2)", obs_x(0), obs_y(0), obs_d(0));
        else pass_cnt++;
        total_cnt++;
        if (bad_timing !== 0) $display("FAIL wall_done_timing: got %0d bad frames want 0", bad_timing);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        int done_at;
        int pulses;
        pulse_reset();
        for (int f = 1; f <= 197; f++) run_frame(32'h0000_0050, done_at, pulses);
        total_cnt++;
        if (obs_x(1) !== 221 || obs_d(1) !== 2)
            $display("FAIL collide_stop: got x %0d d%0d want x 221 d2", obs_x(1), obs_d(1));
        else pass_cnt++;
        for (int f = 198; f <= 200; f++) run_frame(32'h0000_0050, done_at, pulses);
        total_cnt++;
        if (obs_x(1) !== 221 || obs_y(1) !== 232 || obs_d(1) !== 2 || obs_x(0) !== 205)
            $display("FAIL collide_hold: got t1 (%0d,%0d,d%0d) t0 x %0d want t1 (221,232,d2) t0 x 205",
                     obs_x(1), obs_y(1), obs_d(1), obs_x(0));
        else pass_cnt++;
    endtask

    task automatic test_vs_during_update();
        int done_at;
        int pulses;
        keycodes = 32'h0000_0007;
        @(posedge Clk); #1;
        frame_vs = 1'b0;
        done_at  = -1;
        pulses   = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge Clk); #1;
            if (frame_done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = c;
            end
            frame_vs = (c == 2) ? 1'b0 : 1'b1;
        end
        model_frame(32'h0000_0007);
        total_cnt++;
        if (pulses !== 1 || done_at !== N + 1)
            $display("FAIL vs_ignored: got %0d pulses at %0d want 1 at %0d", pulses, done_at, N + 1);
        else pass_cnt++;
        for (int t = 0; t < N; t++) begin
            total_cnt++;
            if (obs_x(t) !== mx[t] || obs_y(t) !== my[t] || obs_d(t) !== mdir[t])
                $display("FAIL vs_ignored_pos t%0d: got (%0d,%0d,d%0d) want (%0d,%0d,d%0d)",
                         t, obs_x(t), obs_y(t), obs_d(t), mx[t], my[t], mdir[t]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_update();
        int pulses;
        keycodes = 32'h0000_5007;
        @(posedge Clk); #1;
        frame_vs = 1'b0;
        pulses   = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge Clk); #1;
            if (frame_done === 1'b1) pulses++;
            frame_vs = 1'b1;
            Reset_n  = (c == 1) ? 1'b0 : 1'b1;
        end
        model_reset();
        total_cnt++;
        if (pulses !== 0) $display("FAIL abort_done: got %0d pulses want 0", pulses);
        else pass_cnt++;
        for (int t = 0; t < N; t++) begin
            total_cnt++;
            if (obs_x(t) !== mx[t] || obs_y(t) !== my[t] || obs_d(t) !== 0)
                $display("FAIL abort_spawn t%0d: got (%0d,%0d,d%0d) want (%0d,%0d,d0)",
                         t, obs_x(t), obs_y(t), obs_d(t), mx[t], my[t]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int               done_at;
        int               pulses;
        int               r;
        int               gap;
        logic [K*8-1:0]   kc;
        logic [7:0]       code;
        pulse_reset();
        for (int f = 0; f < 120; f++) begin
            for (int s = 0; s < K; s++) begin
                r = int'($urandom_range(0, 11));
                if (r < 3) code = 8'h00;
                else if (r == 3) code = 8'h2C;
                else code = bind_code[(r - 4) / 4][(r - 4) % 4];
                kc[s*8 +: 8] = code;
            end
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(posedge Clk);
            run_frame(kc, done_at, pulses);
            total_cnt++;
            if (done_at !== N + 1 || pulses !== 1)
                $display("FAIL rand_done f%0d: got at %0d x%0d want at %0d x1", f, done_at, pulses, N + 1);
            else pass_cnt++;
            for (int t = 0; t < N; t++) begin
                total_cnt++;
                if (obs_x(t) !== mx[t] || obs_y(t) !== my[t] || obs_d(t) !== mdir[t])
                    $display("FAIL rand_pos f%0d t%0d kc %h: got (%0d,%0d,d%0d) want (%0d,%0d,d%0d)",
                             f, t, kc, obs_x(t), obs_y(t), obs_d(t), mx[t], my[t], mdir[t]);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        Reset_n   = 1'b0;
        frame_vs  = 1'b1;
        keycodes  = '0;
        bind_code[0][0] = 8'h1A;
        bind_code[0][1] = 8'h16;
        bind_code[0][2] = 8'h04;
        bind_code[0][3] = 8'h07;
        bind_code[1][0] = 8'h52;
        bind_code[1][1] = 8'h51;
        bind_code[1][2] = 8'h50;
        bind_code[1][3] = 8'h4F;
        for (int t = 0; t < N; t++)
            keymap[t*32 +: 32] = {bind_code[t][0], bind_code[t][1], bind_code[t][2], bind_code[t][3]};

        test_reset();
        test_single_key();
        test_priority();
        test_wall();
        test_collision();
        test_vs_during_update();
        test_reset_mid_update();
        test_random();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
